// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared address/frame/state types for the write-back D-cache
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

   typedef struct packed {
      logic [25:0] tag;
      logic [2:0]  idx;
      logic        blkoff;
      logic [1:0]  bytoff;
   } dcachef_t;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [25:0]      tag;
      logic [1:0][31:0] data;
   } dcache_frame_t;

   typedef enum logic [3:0] {
      IDLE,
      WB0,
      WB1,
      FETCH0,
      FETCH1,
      FLUSH,
      FWB0,
      FWB1,
      CNT,
      HALTED
   } dcache_state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_frame_array.sv
// ============================================================================
// dcache_frame_array : frame storage and per-set LRU bits, one read index,
// one write port. Rev 1.0
// ============================================================================
`default_nettype none

module dcache_frame_array
   import cpu_types_pkg::*;
#(
   parameter int SETS = 8,
   parameter int WAYS = 2
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [2:0]               rd_idx,
   output dcache_frame_t [WAYS-1:0] rd_ways,
   output logic                     rd_lru,
   input  logic [2:0]               wr_idx,
   input  logic                     wr_en,
   input  logic                     wr_way,
   input  dcache_frame_t            wr_frame,
   input  logic                     lru_en,
   input  logic                     lru_val
);

   dcache_frame_t [WAYS-1:0] frames [SETS];
   logic [SETS-1:0]          lru;

   assign rd_ways = frames[rd_idx];
   assign rd_lru  = lru[rd_idx];

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            frames[s] <= '0;
         end
         lru <= '0;
      end else begin
         if (wr_en) begin
            frames[wr_idx][wr_way] <= wr_frame;
         end
         if (lru_en) begin
            lru[wr_idx] <= lru_val;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dcache_wb2way.sv
// ============================================================================
// dcache_wb2way : write-back 2-way L1 data cache with halt-time flush.
// Optional hit/miss counter write-out enabled by DCACHE_HITCOUNT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dcache_wb2way
   import cpu_types_pkg::*;
#(
   parameter int          SETS     = 8,
   parameter int          WAYS     = 2,
   parameter logic [31:0] CNT_ADDR = 32'h3100
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);

`ifdef DCACHE_HITCOUNT_EN
   localparam dcache_state_t FLUSH_DONE = CNT;
`else
   localparam dcache_state_t FLUSH_DONE = HALTED;
`endif

   dcachef_t                 req;
   dcache_state_t            state;
   logic [3:0]               fcnt;
   logic                     victim;
   dcache_frame_t [WAYS-1:0] ways;
   dcache_frame_t            vict;
   dcache_frame_t            fsel;
   dcache_frame_t            wr_frame;
   logic                     lru;
   logic [2:0]               rd_idx;
   logic                     wr_en, wr_way, lru_en, lru_val;
   logic                     hit0, hit1, hit, hit_way, req_any;
   logic                     idle_hit, miss_start, flushing, last_frame;
   logic [31:0]              count_word;
   logic                     unused_bits;

   assign req         = dcachef_t'(dmemaddr);
   assign unused_bits = &{1'b0, req.bytoff};

   assign flushing   = (state == FLUSH) || (state == FWB0) || (state == FWB1);
   assign rd_idx     = flushing ? fcnt[3:1] : req.idx;
   assign last_frame = (fcnt == 4'd15);

   assign vict = ways[victim];
   assign fsel = ways[fcnt[0]];

   assign hit0       = ways[0].valid && (ways[0].tag == req.tag);
   assign hit1       = ways[1].valid && (ways[1].tag == req.tag);
   assign hit        = hit0 || hit1;
   assign hit_way    = !hit0;
   assign req_any    = dmemREN || dmemWEN;
   assign idle_hit   = (state == IDLE) && !halt && req_any && hit;
   assign miss_start = (state == IDLE) && !halt && req_any && !hit;

   assign dhit     = idle_hit;
   assign dmemload = (idle_hit && dmemREN) ? ways[hit_way].data[req.blkoff] : 32'h0;
   assign flushed  = (state == HALTED);

   dcache_frame_array #(
      .SETS (SETS),
      .WAYS (WAYS)
   ) u_frames (
      .CLK      (CLK),
      .nRST     (nRST),
      .rd_idx   (rd_idx),
      .rd_ways  (ways),
      .rd_lru   (lru),
      .wr_idx   (rd_idx),
      .wr_en    (wr_en),
      .wr_way   (wr_way),
      .wr_frame (wr_frame),
      .lru_en   (lru_en),
      .lru_val  (lru_val)
   );

   // Frame/LRU updates; every write targets the set currently being read.
   always_comb begin
      wr_en    = 1'b0;
      wr_way   = 1'b0;
      wr_frame = ways[0];
      lru_en   = 1'b0;
      lru_val  = 1'b0;
      case (state)
         IDLE: begin
            if (idle_hit) begin
               lru_en  = 1'b1;
               lru_val = !hit_way;
               if (dmemWEN) begin
                  wr_en                        = 1'b1;
                  wr_way                       = hit_way;
                  wr_frame                     = ways[hit_way];
                  wr_frame.data[req.blkoff]    = dmemstore;
                  wr_frame.dirty               = 1'b1;
               end
            end
         end
         FETCH0: begin
            wr_en            = !dwait;
            wr_way           = victim;
            wr_frame         = vict;
            wr_frame.data[0] = dload;
         end
         FETCH1: begin
            wr_en            = !dwait;
            wr_way           = victim;
            wr_frame         = vict;
            wr_frame.data[1] = dload;
            wr_frame.valid   = 1'b1;
            wr_frame.dirty   = 1'b0;
            wr_frame.tag     = req.tag;
         end
         FLUSH: begin
            wr_en          = !(fsel.valid && fsel.dirty);
            wr_way         = fcnt[0];
            wr_frame       = fsel;
            wr_frame.valid = 1'b0;
         end
         FWB1: begin
            wr_en          = !dwait;
            wr_way         = fcnt[0];
            wr_frame       = fsel;
            wr_frame.valid = 1'b0;
            wr_frame.dirty = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = 32'h0;
      dstore = 32'h0;
      case (state)
         WB0, WB1: begin
            dWEN   = 1'b1;
            daddr  = {vict.tag, req.idx, (state == WB1), 2'b00};
            dstore = vict.data[state == WB1];
         end
         FETCH0, FETCH1: begin
            dREN  = 1'b1;
            daddr = {req.tag, req.idx, (state == FETCH1), 2'b00};
         end
         FWB0, FWB1: begin
            dWEN   = 1'b1;
            daddr  = {fsel.tag, fcnt[3:1], (state == FWB1), 2'b00};
            dstore = fsel.data[state == FWB1];
         end
         CNT: begin
            dWEN   = 1'b1;
            daddr  = CNT_ADDR;
            dstore = count_word;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         fcnt   <= 4'd0;
         victim <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt) begin
                  state <= FLUSH;
                  fcnt  <= 4'd0;
               end else if (miss_start) begin
                  victim <= lru;
                  state  <= (ways[lru].valid && ways[lru].dirty) ? WB0 : FETCH0;
               end
            end
            WB0:    if (!dwait) state <= WB1;
            WB1:    if (!dwait) state <= FETCH0;
            FETCH0: if (!dwait) state <= FETCH1;
            FETCH1: if (!dwait) state <= IDLE;
            FLUSH: begin
               if (fsel.valid && fsel.dirty) begin
                  state <= FWB0;
               end else if (last_frame) begin
                  state <= FLUSH_DONE;
               end else begin
                  fcnt <= fcnt + 4'd1;
               end
            end
            FWB0: if (!dwait) state <= FWB1;
            FWB1: begin
               if (!dwait) begin
                  if (last_frame) begin
                     state <= FLUSH_DONE;
                  end else begin
                     fcnt  <= fcnt + 4'd1;
                     state <= FLUSH;
                  end
               end
            end
            CNT:     if (!dwait) state <= HALTED;
            HALTED:  state <= HALTED;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_HITCOUNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   logic        miss_pend;

   // The hit that completes a miss is not a new access and is not counted.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         hit_cnt   <= 32'h0;
         miss_cnt  <= 32'h0;
         miss_pend <= 1'b0;
      end else if (miss_start) begin
         miss_cnt  <= miss_cnt + 32'h1;
         miss_pend <= 1'b1;
      end else if (idle_hit) begin
         if (miss_pend) begin
            miss_pend <= 1'b0;
         end else begin
            hit_cnt <= hit_cnt + 32'h1;
         end
      end
   end

   assign count_word = hit_cnt - miss_cnt;
`else
   assign count_word = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb2way.sv
// ============================================================================
// tb_dcache_wb2way : randomized self-checking bench with an LRU-timestamp
// cache model and a memory responder. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dcache_wb2way;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, halt;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit, flushed, dREN, dWEN;
   logic [31:0] dmemload, daddr, dstore;
   logic        dwait = 1'b0;
   logic [31:0] dload = 32'h0;

   dcache_wb2way dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .dmemREN   (dmemREN),
      .dmemWEN   (dmemWEN),
      .dmemaddr  (dmemaddr),
      .dmemstore (dmemstore),
      .halt      (halt),
      .dhit      (dhit),
      .dmemload  (dmemload),
      .flushed   (flushed),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dwait     (dwait),
      .dload     (dload)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [31:0] mem [logic [31:0]];
   logic [63:0] act_wr [$];
   logic [63:0] exp_wr [$];
   logic [31:0] act_rd [$];
   logic [31:0] exp_rd [$];
   int          busy     = 2;
   bit          lat_rand = 1'b0;

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   always @(posedge CLK) begin
      if ((dREN || dWEN) && !dwait) begin
         if (dWEN) begin
            act_wr.push_back({daddr, dstore});
            mem[daddr] = dstore;
         end else begin
            act_rd.push_back(daddr);
         end
         busy = lat_rand ? int'($urandom_range(0, 2)) : 2;
      end
   end

   always @(negedge CLK) begin
      if ((dREN || dWEN) && busy > 0) begin
         dwait = 1'b1;
         busy--;
      end else begin
         dwait = 1'b0;
      end
      dload = memrd(daddr);
   end

   // ---------------- reference model: LRU by last-use timestamp ----------------
   typedef struct {
      bit               valid;
      bit               dirty;
      logic [25:0]      tag;
      logic [1:0][31:0] d;
      longint           ts;
   } mline_t;

   mline_t      ml [8][2];
   longint      now;
   logic [31:0] m_hits, m_misses;

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            ml[s][w].valid = 1'b0;
            ml[s][w].dirty = 1'b0;
            ml[s][w].tag   = '0;
            ml[s][w].d     = '0;
            ml[s][w].ts    = 0;
         end
      end
      now = 0; m_hits = 0; m_misses = 0;
      exp_wr.delete(); exp_rd.delete(); act_wr.delete(); act_rd.delete();
   endtask

   task automatic model_access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                               output bit hit, output logic [31:0] ld);
      int s = int'(a[5:3]);
      logic [25:0] t = a[31:6];
      int o = int'(a[2]);
      int w = -1;
      now++;
      for (int i = 0; i < 2; i++)
         if (ml[s][i].valid && ml[s][i].tag == t) w = i;
      hit = (w >= 0);
      if (!hit) begin
         int v = (ml[s][1].ts < ml[s][0].ts) ? 1 : 0;
         m_misses++;
         if (ml[s][v].valid && ml[s][v].dirty) begin
            exp_wr.push_back({ml[s][v].tag, a[5:3], 1'b0, 2'b00, ml[s][v].d[0]});
            exp_wr.push_back({ml[s][v].tag, a[5:3], 1'b1, 2'b00, ml[s][v].d[1]});
         end
         exp_rd.push_back({t, a[5:3], 1'b0, 2'b00});
         exp_rd.push_back({t, a[5:3], 1'b1, 2'b00});
         ml[s][v].valid = 1'b1;
         ml[s][v].dirty = 1'b0;
         ml[s][v].tag   = t;
         ml[s][v].d[0]  = memrd({t, a[5:3], 1'b0, 2'b00});
         ml[s][v].d[1]  = memrd({t, a[5:3], 1'b1, 2'b00});
         w = v;
      end else begin
         m_hits++;
      end
      ml[s][w].ts = now;
      ld = ml[s][w].d[o];
      if (we) begin
         ml[s][w].d[o]  = wd;
         ml[s][w].dirty = 1'b1;
      end
   endtask

   task automatic check_traffic();
      check("wr_count", 64'(act_wr.size()), 64'(exp_wr.size()));
      while (act_wr.size() > 0 && exp_wr.size() > 0)
         check("wr_addr_data", act_wr.pop_front(), exp_wr.pop_front());
      check("rd_count", 64'(act_rd.size()), 64'(exp_rd.size()));
      while (act_rd.size() > 0 && exp_rd.size() > 0)
         check("rd_addr", 64'(act_rd.pop_front()), 64'(exp_rd.pop_front()));
      act_wr.delete(); exp_wr.delete(); act_rd.delete(); exp_rd.delete();
   endtask

   // Called at a negedge; returns the DUT's dhit on the first request cycle.
   task automatic do_access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                            output logic first_hit);
      bit          mhit;
      logic [31:0] mld;
      int          n = 0;
      model_access(a, we, wd, mhit, mld);
      dmemaddr = a; dmemstore = wd; dmemREN = !we; dmemWEN = we;
      #1;
      first_hit = dhit;
      check("dhit_first", 64'(dhit), 64'(mhit));
      if (!mhit) begin
         while (!dhit && n < 100) begin
            @(negedge CLK); #1; n++;
         end
         check("miss_complete", 64'(dhit), 64'd1);
      end
      if (!we) check("dmemload", 64'(dmemload), 64'(mld));
      @(posedge CLK); #1;
      dmemREN = 1'b0; dmemWEN = 1'b0;
      @(negedge CLK);
      check_traffic();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h;
      int   n;
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
      dmemaddr = '0; dmemstore = '0;
      model_reset();
      repeat (2) @(negedge CLK);
      #1;
      check("reset_outputs", {dhit, flushed, dREN, dWEN, dmemload, daddr[27:0]}, 64'd0);
      check("reset_dstore", 64'(dstore), 64'd0);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      // Cold load, then same-line hit, fixed 2-cycle latency.
      do_access(32'h100, 1'b0, 32'h0, h);
      do_access(32'h104, 1'b0, 32'h0, h);
      check("p1_hit_104", 64'(h), 64'd1);
      do_access(32'h100, 1'b1, 32'hDEAD_BEEF, h);
      check("p2_store_hit", 64'(h), 64'd1);
      do_access(32'h140, 1'b0, 32'h0, h);
      do_access(32'h180, 1'b0, 32'h0, h);
      do_access(32'h000, 1'b0, 32'h0, h);
      do_access(32'h040, 1'b0, 32'h0, h);
      do_access(32'h000, 1'b0, 32'h0, h);
      do_access(32'h080, 1'b0, 32'h0, h);
      do_access(32'h000, 1'b0, 32'h0, h);
      check("p3_hit_000", 64'(h), 64'd1);

      lat_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = {24'h0, 2'($urandom_range(0, 3)), 3'($urandom), 1'($urandom), 2'b00};
         do_access(a, ($urandom_range(0, 9) < 4), $urandom, h);
      end

      // Reset in the middle of a dirty-line writeback.
      lat_rand = 1'b0;
      do_access(32'h000, 1'b1, 32'h1111_0000, h);
      do_access(32'h040, 1'b1, 32'h2222_0000, h);
      begin
         bit          mh;
         logic [31:0] ml_d;
         model_access(32'h080, 1'b0, 32'h0, mh, ml_d);
      end
      dmemaddr = 32'h080; dmemREN = 1'b1;
      n = 0;
      #1;
      while (!(dWEN && daddr[2]) && n < 100) begin
         @(negedge CLK); #1; n++;
      end
      check("reach_wb1", 64'(dWEN && daddr[2]), 64'd1);
      nRST = 1'b0;
      #1;
      check("abort_outputs", {dhit, flushed, dREN, dWEN, dmemload, daddr[27:0]}, 64'd0);
      check("abort_dstore", 64'(dstore), 64'd0);
      dmemREN = 1'b0;
      repeat (2) begin
         @(negedge CLK); #1;
         check("abort_no_dwen", 64'(dWEN), 64'd0);
      end
      check("abort_wr_count", 64'(act_wr.size()), 64'd1);
      if (act_wr.size() > 0 && exp_wr.size() > 0)
         check("abort_wb0", act_wr[0], exp_wr[0]);
      model_reset();
      nRST = 1'b1;
      @(negedge CLK);
      do_access(32'h080, 1'b0, 32'h0, h);
      check("post_reset_miss", 64'(h), 64'd0);

      // Dirty lines in sets 0, 3, 7 then flush.
      lat_rand = 1'b1;
      do_access(32'h000, 1'b1, 32'hA000_0000, h);
      do_access(32'h018, 1'b1, 32'hA000_0003, h);
      do_access(32'h038, 1'b1, 32'hA000_0007, h);
      do_access(32'h004, 1'b0, 32'h0, h);
      do_access(32'h01C, 1'b0, 32'h0, h);
      do_access(32'h03C, 1'b0, 32'h0, h);
      do_access(32'h000, 1'b1, 32'hA000_1000, h);
      do_access(32'h080, 1'b0, 32'h0, h);

      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < 2; w++) begin
            if (ml[s][w].valid && ml[s][w].dirty) begin
               exp_wr.push_back({ml[s][w].tag, 3'(s), 1'b0, 2'b00, ml[s][w].d[0]});
               exp_wr.push_back({ml[s][w].tag, 3'(s), 1'b1, 2'b00, ml[s][w].d[1]});
            end
         end
      end
`ifdef DCACHE_HITCOUNT_EN
      exp_wr.push_back({32'h3100, m_hits - m_misses});
      n = 7;
`else
      n = 6;
`endif
      halt = 1'b1;
      begin
         int c = 0;
         #1;
         while (!flushed && c < 2000) begin
            @(negedge CLK); #1; c++;
         end
      end
      check("flushed", 64'(flushed), 64'd1);
      check("flush_wr_total", 64'(act_wr.size()), 64'(n));
      check_traffic();
      for (int i = 0; i < 5; i++) begin
         dmemaddr = 32'h004; dmemREN = 1'b1;
         @(negedge CLK); #1;
         check("halted_state", {61'd0, flushed, dhit, dREN | dWEN}, 64'd4);
      end
      dmemREN = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
